// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the memory-access stage.
//   - bus widths of the EX->MEM and MEM->WB payloads
//   - load-type encodings carried in ld_op
//   - bit-field offsets of both buses, plus packed structs with the same layout
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 75;
  localparam int MS_TO_WS_BUS_WD = 71;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_BU = 3'b010;
  localparam logic [2:0] LD_H  = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  // EX->MEM bus field offsets (LSB of each field)
  localparam int ES_RES_FROM_MEM = 74;
  localparam int ES_LD_OP_LSB    = 71;
  localparam int ES_GR_WE        = 70;
  localparam int ES_DEST_LSB     = 65;
  localparam int ES_ALU_LSB      = 33;
  localparam int ES_PC_LSB       = 1;
  localparam int ES_IS_EXC       = 0;

  // MEM->WB bus field offsets (LSB of each field)
  localparam int MS_GR_WE        = 70;
  localparam int MS_DEST_LSB     = 65;
  localparam int MS_RESULT_LSB   = 33;
  localparam int MS_PC_LSB       = 1;
  localparam int MS_IS_EXC       = 0;

  typedef struct packed {
    logic        res_from_mem;
    logic [2:0]  ld_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic        is_exc;
  } es_to_ms_t;

  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
    logic        is_exc;
  } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_ld_align.sv
// ld_align: combinational load-data alignment and extension.
//   ld_op  in  3  - load type (W/B/BU/H/HU, unknown codes behave as W)
//   offset in  2  - byte address bits [1:0]; halfword uses offset[1]
//   word   in 32  - raw 32-bit data word
//   result out 32 - aligned, sign/zero-extended load value
// Kept free of any stage state so the cache path can reuse it.
module ld_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] result
);

  function automatic logic signed [31:0] sext8(input logic signed [7:0] b);
    return 32'(b);
  endfunction

  function automatic logic signed [31:0] sext16(input logic signed [15:0] h);
    return 32'(h);
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    result = word;
    case (ld_op)
      LD_B:    result = sext8(byte_sel);
      LD_BU:   result = {24'd0, byte_sel};
      LD_H:    result = sext16(half_sel);
      LD_HU:   result = {16'd0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback.
//   clk, resetn                      - clock, asynchronous active-low reset
//   es_to_ms_valid/es_to_ms_bus      - EX payload in (75 bits)
//   ms_allowin                       - stage can take an EX payload this cycle
//   data_sram_data_ok/_rdata         - in-order load responses
//   ws_allowin, ws_flush             - WB backpressure and exception flush
//   ms_to_ws_valid/ms_to_ws_bus      - payload out to WB (71 bits)
//   ms_to_ds_dest/_result/_ld_pending- forwarding and load-use stall view for decode
//   ms_stall_cnt                     - load stall cycle counter
// Optional feature: define MS_STALL_CNT_EN to build the stall counter;
// otherwise ms_stall_cnt is tied to zero.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_to_ms_valid,
  input  logic [74:0] es_to_ms_bus,
  output logic        ms_allowin,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  input  logic        ws_flush,
  output logic        ms_to_ws_valid,
  output logic [70:0] ms_to_ws_bus,
  output logic [4:0]  ms_to_ds_dest,
  output logic [31:0] ms_to_ds_result,
  output logic        ms_to_ds_ld_pending,
  output logic [31:0] ms_stall_cnt
);

  es_to_ms_t   ms_bus_p0;
  ms_to_ws_t   ws_bus;
  logic        ms_vld_p0;
  logic        buf_vld_p0;
  logic [31:0] buf_data_p0;
  logic        discard_p0;

  logic        data_ok_acc;
  logic        ms_ready_go;
  logic        buf_take;
  logic        discard_set;
  logic [31:0] ld_word;
  logic [31:0] ld_result;
  logic [31:0] final_result;

  // A response arriving while discard is set belongs to a flushed load.
  assign data_ok_acc = data_sram_data_ok && !discard_p0;
  assign ms_ready_go = !ms_bus_p0.res_from_mem || buf_vld_p0 || data_ok_acc;
  assign ms_allowin  = !ms_vld_p0 || (ms_ready_go && ws_allowin);

  assign ms_to_ws_valid      = ms_vld_p0 && ms_ready_go && !ws_flush;
  assign ms_to_ds_ld_pending = ms_vld_p0 && ms_bus_p0.res_from_mem && !ms_ready_go;
  assign ms_to_ds_dest       = ms_bus_p0.dest & {5{ms_vld_p0 && ms_bus_p0.gr_we}};

  // Park the response when WB is not accepting, so the SRAM word is not lost.
  assign buf_take = data_ok_acc && ms_vld_p0 && ms_bus_p0.res_from_mem &&
                    !buf_vld_p0 && !ws_allowin && !ws_flush;

  // A flushed load that has not seen its response still has one in flight.
  assign discard_set = ws_flush && ms_vld_p0 && ms_bus_p0.res_from_mem &&
                       !buf_vld_p0 && !data_sram_data_ok;

  assign ld_word = buf_vld_p0 ? buf_data_p0 : data_sram_rdata;

  ld_align u_ld_align (
    .ld_op  (ms_bus_p0.ld_op),
    .offset (ms_bus_p0.alu_result[1:0]),
    .word   (ld_word),
    .result (ld_result)
  );

  assign final_result = ms_bus_p0.res_from_mem ? ld_result : ms_bus_p0.alu_result;

  always_comb begin
    ws_bus.gr_we        = ms_bus_p0.gr_we;
    ws_bus.dest         = ms_bus_p0.dest;
    ws_bus.final_result = final_result;
    ws_bus.pc           = ms_bus_p0.pc;
    ws_bus.is_exc       = ms_bus_p0.is_exc;
  end

  assign ms_to_ws_bus    = ws_bus;
  assign ms_to_ds_result = final_result;

  // ---- p0: EX -> MEM register boundary ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_vld_p0  <= 1'b0;
      ms_bus_p0  <= '0;
      buf_vld_p0 <= 1'b0;
      discard_p0 <= 1'b0;
    end else begin
      if (ws_flush)
        ms_vld_p0 <= 1'b0;
      else if (ms_allowin)
        ms_vld_p0 <= es_to_ms_valid;

      if (es_to_ms_valid && ms_allowin)
        ms_bus_p0 <= es_to_ms_bus;

      if (ws_flush || (ms_to_ws_valid && ws_allowin))
        buf_vld_p0 <= 1'b0;
      else if (buf_take)
        buf_vld_p0 <= 1'b1;

      if (discard_set)
        discard_p0 <= 1'b1;
      else if (data_sram_data_ok)
        discard_p0 <= 1'b0;
    end
  end

  // Buffered word is only observed while buf_vld_p0 is set.
  always_ff @(posedge clk) begin
    if (buf_take)
      buf_data_p0 <= data_sram_rdata;
  end

`ifdef MS_STALL_CNT_EN
  logic [31:0] stall_cnt_p0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      stall_cnt_p0 <= '0;
    else if (ms_vld_p0 && !ms_ready_go)
      stall_cnt_p0 <= stall_cnt_p0 + 32'd1;
  end

  assign ms_stall_cnt = stall_cnt_p0;
`else
  assign ms_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a
// transaction-level reference model kept in the bench.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        es_valid;
  logic [74:0] es_bus;
  logic        ms_allowin;
  logic        data_ok;
  logic [31:0] rdata;
  logic        ws_allowin;
  logic        ws_flush;
  logic        tows;
  logic [70:0] bus;
  logic [4:0]  ds_dest;
  logic [31:0] ds_result;
  logic        ld_pend;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk                 (clk),
    .resetn              (resetn),
    .es_to_ms_valid      (es_valid),
    .es_to_ms_bus        (es_bus),
    .ms_allowin          (ms_allowin),
    .data_sram_data_ok   (data_ok),
    .data_sram_rdata     (rdata),
    .ws_allowin          (ws_allowin),
    .ws_flush            (ws_flush),
    .ms_to_ws_valid      (tows),
    .ms_to_ws_bus        (bus),
    .ms_to_ds_dest       (ds_dest),
    .ms_to_ds_result     (ds_result),
    .ms_to_ds_ld_pending (ld_pend),
    .ms_stall_cnt        (stall_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the instruction sitting in MEM, whether its load word
  // has been parked, and how many stale responses are still owed by the SRAM.
  logic        m_valid;
  logic [74:0] m_bus;
  logic        m_have;
  logic [31:0] m_buf;
  int          stale;
  logic [31:0] m_cnt;
  // Expectations of the current cycle, reused by the state update
  logic        e_ready, e_allowin, e_tows, e_cur_ok;

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [74:0] mk(input logic rfm, input logic [2:0] op, input logic we,
                                     input logic [4:0] dst, input logic [31:0] alu,
                                     input logic [31:0] pc, input logic exc);
    return {rfm, op, we, dst, alu, pc, exc};
  endfunction

  // Load value from the word by plain arithmetic on the addressed byte/halfword.
  function automatic logic [31:0] m_extract(input logic [2:0] op, input logic [1:0] off,
                                            input logic [31:0] w);
    int unsigned sh;
    logic [31:0] v;
    case (op)
      3'd1, 3'd2: begin
        sh = 8 * int'(off);
        v  = (w >> sh) & 32'hFF;
        if (op == 3'd1 && v >= 32'd128) v = v - 32'd256;
        return v;
      end
      3'd3, 3'd4: begin
        sh = 16 * int'(off[1]);
        v  = (w >> sh) & 32'hFFFF;
        if (op == 3'd3 && v >= 32'h8000) v = v - 32'h10000;
        return v;
      end
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_bus   = '0;
    m_have  = 1'b0;
    m_buf   = '0;
    stale   = 0;
    m_cnt   = '0;
  endtask

  task automatic idle();
    es_valid   = 1'b0;
    es_bus     = '0;
    data_ok    = 1'b0;
    rdata      = $urandom;
    ws_allowin = 1'b1;
    ws_flush   = 1'b0;
  endtask

  // Let inputs settle, then compare every output with the model.
  task automatic settle();
    logic        rfm;
    logic [31:0] alu, word, fin;
    logic [70:0] e_bus;
    logic [31:0] e_cnt;
    #1;
    rfm       = m_bus[74];
    alu       = m_bus[64:33];
    e_cur_ok  = data_ok && (stale == 0);
    e_ready   = !rfm || m_have || e_cur_ok;
    e_allowin = !m_valid || (e_ready && ws_allowin);
    e_tows    = m_valid && e_ready && !ws_flush;
    word      = m_have ? m_buf : rdata;
    fin       = rfm ? m_extract(m_bus[73:71], alu[1:0], word) : alu;
    e_bus     = {m_bus[70], m_bus[69:65], fin, m_bus[32:1], m_bus[0]};
`ifdef MS_STALL_CNT_EN
    e_cnt = m_cnt;
`else
    e_cnt = '0;
`endif
    chk("allowin",    71'(ms_allowin), 71'(e_allowin));
    chk("to_ws_valid", 71'(tows),      71'(e_tows));
    chk("to_ws_bus",  bus,             e_bus);
    chk("ds_dest",    71'(ds_dest),    71'(m_bus[69:65] & {5{m_valid && m_bus[70]}}));
    chk("ds_result",  71'(ds_result),  71'(fin));
    chk("ld_pending", 71'(ld_pend),    71'(m_valid && rfm && !e_ready));
    chk("stall_cnt",  71'(stall_cnt),  71'(e_cnt));
  endtask

  // Take the clock edge and move the model on with this cycle's inputs.
  task automatic advance();
    logic rfm;
    rfm = m_bus[74];
    @(posedge clk);
    if (!resetn) begin
      model_reset();
    end else begin
      if (data_ok && stale > 0) stale--;
      if (ws_flush && m_valid && rfm && !m_have && !data_ok) stale++;
      if (m_valid && !e_ready) m_cnt = m_cnt + 32'd1;
      if (ws_flush || (e_tows && ws_allowin))
        m_have = 1'b0;
      else if (e_cur_ok && m_valid && rfm && !m_have && !ws_allowin) begin
        m_have = 1'b1;
        m_buf  = rdata;
      end
      if (es_valid && e_allowin) m_bus = es_bus;
      if (ws_flush) m_valid = 1'b0;
      else if (e_allowin) m_valid = es_valid;
    end
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    int pend;
    pend       = stale + ((m_valid && m_bus[74] && !m_have) ? 1 : 0);
    es_valid   = ($urandom_range(0, 9) < 6);
    es_bus     = mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom), $urandom, $urandom, 1'($urandom_range(0, 1)));
    data_ok    = (pend > 0) && ($urandom_range(0, 9) < 4);
    rdata      = $urandom;
    ws_allowin = ($urandom_range(0, 9) < 7);
    ws_flush   = (stale == 0) && ($urandom_range(0, 19) == 0);
  endtask

  // Issue one load, then answer it on the very next cycle.
  task automatic quick_load(input logic [2:0] op, input logic [31:0] alu,
                            input logic [31:0] word, input logic [31:0] want, input string name);
    idle();
    es_valid = 1'b1;
    es_bus   = mk(1'b1, op, 1'b1, 5'd7, alu, 32'h1c000100, 1'b0);
    settle();
    advance();
    idle();
    data_ok = 1'b1;
    rdata   = word;
    settle();
    chk({name, "_valid"}, 71'(tows), 71'(1));
    chk(name, 71'(bus[64:33]), 71'(want));
    advance();
  endtask

  int deliv;

  initial begin
    model_reset();
    resetn = 1'b0;
    idle();
    @(negedge clk);
    settle();
    chk("rst_allowin", 71'(ms_allowin), 71'(1));
    chk("rst_valid",   71'(tows),       71'(0));
    chk("rst_bus",     bus,             71'(0));
    chk("rst_cnt",     71'(stall_cnt),  71'(0));
    advance();
    resetn = 1'b1;

    // ALU op passes straight through
    idle();
    es_valid = 1'b1;
    es_bus   = mk(1'b0, 3'd0, 1'b1, 5'd5, 32'h12345678, 32'h1c000000, 1'b0);
    settle();
    advance();

    // LD.B offset 3, response two cycles late
    idle();
    es_valid = 1'b1;
    es_bus   = mk(1'b1, 3'd1, 1'b1, 5'd6, 32'h00001003, 32'h1c000004, 1'b0);
    settle();
    chk("alu_valid",  71'(tows),        71'(1));
    chk("alu_result", 71'(bus[64:33]),  71'(32'h12345678));
    chk("alu_pc",     71'(bus[32:1]),   71'(32'h1c000000));
    advance();
    for (int i = 0; i < 2; i++) begin
      idle();
      settle();
      chk("ldb_pending", 71'(ld_pend), 71'(1));
      advance();
    end
    idle();
    data_ok = 1'b1;
    rdata   = 32'h80FF0000;
    settle();
    chk("ldb_valid",  71'(tows),       71'(1));
    chk("ldb_result", 71'(bus[64:33]), 71'(32'hFFFFFF80));
    advance();
    idle();
    settle();
`ifdef MS_STALL_CNT_EN
    chk("stall_cnt_two", 71'(stall_cnt), 71'(2));
`else
    chk("stall_cnt_off", 71'(stall_cnt), 71'(0));
`endif
    advance();

    quick_load(3'd2, 32'h00001003, 32'h80FF0000, 32'h00000080, "ldbu");
    quick_load(3'd3, 32'h00002002, 32'h80017FFF, 32'hFFFF8001, "ldh");
    quick_load(3'd4, 32'h00002002, 32'h80017FFF, 32'h00008001, "ldhu");

    // Backpressure: response parked while WB stalls, delivered once on release
    deliv = 0;
    idle();
    es_valid = 1'b1;
    es_bus   = mk(1'b1, 3'd0, 1'b1, 5'd9, 32'h00000100, 32'h1c000200, 1'b0);
    settle();
    advance();
    idle();
    ws_allowin = 1'b0;
    data_ok    = 1'b1;
    rdata      = 32'hCAFEBABE;
    settle();
    chk("bp_allowin0", 71'(ms_allowin), 71'(0));
    advance();
    for (int i = 0; i < 2; i++) begin
      idle();
      ws_allowin = 1'b0;
      settle();
      chk("bp_hold_allowin", 71'(ms_allowin), 71'(0));
      chk("bp_hold_result",  71'(bus[64:33]), 71'(32'hCAFEBABE));
      if (tows && ws_allowin) deliv++;
      advance();
    end
    idle();
    settle();
    chk("bp_rel_allowin", 71'(ms_allowin), 71'(1));
    chk("bp_rel_result",  71'(bus[64:33]), 71'(32'hCAFEBABE));
    if (tows && ws_allowin) deliv++;
    advance();
    idle();
    settle();
    if (tows && ws_allowin) deliv++;
    chk("bp_delivered_once", 71'(deliv), 71'(1));
    advance();

    // Flush during an outstanding load: its late response must be dropped
    idle();
    es_valid = 1'b1;
    es_bus   = mk(1'b1, 3'd0, 1'b1, 5'd10, 32'h00000300, 32'h1c000300, 1'b0);
    settle();
    advance();
    idle();
    ws_flush = 1'b1;
    settle();
    chk("fl_valid", 71'(tows), 71'(0));
    advance();
    idle();
    es_valid = 1'b1;
    es_bus   = mk(1'b1, 3'd0, 1'b1, 5'd11, 32'h00000304, 32'h1c000304, 1'b0);
    settle();
    advance();
    idle();
    data_ok = 1'b1;
    rdata   = 32'hDEADBEEF;
    settle();
    chk("fl_drop_valid",   71'(tows),    71'(0));
    chk("fl_drop_pending", 71'(ld_pend), 71'(1));
    advance();
    idle();
    data_ok = 1'b1;
    rdata   = 32'h00000011;
    settle();
    chk("fl_next_valid",  71'(tows),       71'(1));
    chk("fl_next_result", 71'(bus[64:33]), 71'(32'h00000011));
    advance();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      settle();
      advance();
    end

    // Asynchronous reset in the middle of a cycle
    idle();
    #2 resetn = 1'b0;
    #1;
    chk("arst_allowin", 71'(ms_allowin), 71'(1));
    chk("arst_valid",   71'(tows),       71'(0));
    chk("arst_bus",     bus,             71'(0));
    chk("arst_pending", 71'(ld_pend),    71'(0));
    chk("arst_cnt",     71'(stall_cnt),  71'(0));
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      settle();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
